sh7604_dbus_arb: RTL and testbench
==================================

# sh7604_dbus_arb

Arbiter and sequencer for the SH7604 external data bus (DBUS). It shares the bus between three masters: the CPU core port, the on-chip DMAC, and an external bus master (the second SH2 in master/slave configurations, via BREQ/BACK). It also decides grant hand-over at access boundaries and honours lock and burst sequences. It sits between the CPU/DMAC bus-request logic and the BSC, and drives the BSC owner select.

## Interface
- `MAX_HOLD`, default 8: consecutive completed DMAC accesses before the CPU is given one slot. Used only under `SH7604_ARB_FAIR_EN`. Range 1..255.
- `CLK` in 1: system clock.
- `RST` in 1: asynchronous, active-high reset.
- `CE_R` in 1: rising-phase clock enable. All state updates happen on `CLK` when `CE_R`=1.
- `CE_F` in 1: falling-phase enable. Access completion is sampled on it.
- `CPU_REQ`, `CPU_LOCK`, `CPU_BURST` in 1 each: CPU bus request and its attributes.
- `DMA_REQ`, `DMA_LOCK`, `DMA_BURST` in 1 each: DMAC bus request and its attributes.
- `EXT_BREQ` in 1: external master bus request, active-high internally.
- `DBUS_WAIT` in 1: BSC wait. An access completes on `CE_F` with owner REQ=1 and `DBUS_WAIT`=0.
- `GNT_CPU`, `GNT_DMA` out 1 each: registered grants.
- `EXT_BACK` out 1: bus acknowledge to the external master. It is the registered grant for the external master.
- `BUS_SEL` out 2: current owner. 00 none, 01 CPU, 10 DMAC, 11 external.
- `CPU_WAIT` out 1: combinational, `CPU_REQ & ~GNT_CPU`.
- `ACC_DONE` out 1: one-CLK pulse on each completed access of the current owner.

## Operation
- States: IDLE, CPU, DMA, EXT, TURN.
- Reset state: IDLE. All outputs are 0 except `CPU_WAIT`, which follows `CPU_REQ`. The hold counter and the `DONE` latch reset to 0.
- Priority in IDLE: `EXT_BREQ` > `DMA_REQ` > `CPU_REQ`.
  - EXT goes via TURN.
  - DMA and CPU go directly to their state, with the grant asserted on the same CE_R update.
- Re-arbitration point, with owner CPU or DMA. It occurs when either:
  - the owner's REQ is 0; or
  - the owner's REQ is 1, a completion was latched since the last CE_R, and both LOCK and BURST of the owner are 0.
- At a re-arbitration point:
  - The IDLE priority rules are applied.
  - If the same owner wins, the grant stays asserted with no gap.
  - A different CPU/DMA owner is switched in directly.
  - If nothing requests, go to IDLE.
- Lock/burst: while the owner holds LOCK or BURST at 1, no other master is granted, including `EXT_BREQ`.
- EXT entry: CPU/DMA → TURN → EXT.
  - TURN lasts exactly one CE_R update with all grants 0 and `BUS_SEL`=00.
  - `EXT_BACK`=1 in EXT.
- EXT exit: when `EXT_BREQ`=0, go EXT → TURN → IDLE. `EXT_BREQ` is ignored in TURN.
- Completion latch:
  - Set on `CE_F` when the owner REQ=1 and `DBUS_WAIT`=0.
  - `ACC_DONE` pulses on that same CLK.
  - Cleared on the next CE_R update.
  - If `CE_F` and `CE_R` coincide, the set takes effect first and the CE_R update uses it.
- Owner REQ drop mid-access with `DBUS_WAIT`=1: the grant is held until the completion is latched. The bus is never torn from the BSC mid-cycle.
- Reset mid-operation: all grants drop immediately (asynchronously). This includes `EXT_BACK`.

## Timing
- Idle request to grant: 1 CE_R update.
- Request to `EXT_BACK`: 2 CE_R updates from IDLE.
- Hand-over CPU↔DMA at an unlocked boundary: 0 dead cycles.
- Hand-over to/from EXT: exactly 1 dead CE_R cycle (TURN).
- Grants are glitch-free registered outputs. `BUS_SEL` is always consistent with the grants.
- Simultaneous `DMA_REQ` and `CPU_REQ` rise in IDLE: DMA is granted.

## Configuration
- `SH7604_ARB_FAIR_EN` defined:
  - An 8-bit hold counter increments on each DMA completion.
  - At a re-arbitration point with the counter ≥ `MAX_HOLD`, `CPU_REQ`=1 and DMA not locked, the CPU wins over the DMA for one access, and the counter clears.
  - The counter also clears whenever the CPU is granted or the state is IDLE.
- Not defined:
  - Pure fixed priority. The CPU is starved while `DMA_REQ` stays high.
  - No counter logic is synthesized.

## Test plan
- `CPU_REQ`=1 from reset, `DBUS_WAIT`=0 → `GNT_CPU`=1 and `BUS_SEL`=01 after 1 CE_R, and `ACC_DONE` pulses each `CE_F`.
- CPU owner with `CPU_LOCK`=1 for 3 accesses, `DMA_REQ` raised during access 1 → `GNT_DMA` rises only on the CE_R after the 3rd completion with LOCK=0, with no dead cycle.
- DMA owner, `EXT_BREQ` asserted, `DBUS_WAIT`=1 for 4 cycles → the grant is held until completion. Then TURN (`BUS_SEL`=00) for one CE_R, then `EXT_BACK`=1. Dropping `EXT_BREQ` gives TURN then IDLE.
- `SH7604_ARB_FAIR_EN`, `MAX_HOLD`=8, `DMA_REQ` and `CPU_REQ` held at 1 → 8 DMA accesses, 1 CPU access, repeating. Without the macro: the CPU is never granted.
- `RST` pulsed while in EXT → `EXT_BACK`=0 and all grants 0 asynchronously. The state is IDLE after release.
- `DMA_REQ`/`CPU_REQ` both rise on the same CE_R in IDLE → `GNT_DMA`=1 and `CPU_WAIT`=1.

Source files
------------

// File: rtl/sh7604_dbus_arb_if.sv
// sh7604_dbus_arb_if: DBUS request/grant bundle between the bus masters and the arbiter.
// master: drives clock enables, requests, attributes and BSC wait; sees grants.
// slave: the arbiter side.
interface sh7604_dbus_arb_if;
  logic CE_R, CE_F;
  logic CPU_REQ, CPU_LOCK, CPU_BURST;
  logic DMA_REQ, DMA_LOCK, DMA_BURST;
  logic EXT_BREQ, DBUS_WAIT;
  logic GNT_CPU, GNT_DMA, EXT_BACK, CPU_WAIT, ACC_DONE;
  logic [1:0] BUS_SEL;
  modport master (
    output CE_R, CE_F, CPU_REQ, CPU_LOCK, CPU_BURST, DMA_REQ, DMA_LOCK, DMA_BURST, EXT_BREQ, DBUS_WAIT,
    input  GNT_CPU, GNT_DMA, EXT_BACK, CPU_WAIT, ACC_DONE, BUS_SEL
  );
  modport slave (
    input  CE_R, CE_F, CPU_REQ, CPU_LOCK, CPU_BURST, DMA_REQ, DMA_LOCK, DMA_BURST, EXT_BREQ, DBUS_WAIT,
    output GNT_CPU, GNT_DMA, EXT_BACK, CPU_WAIT, ACC_DONE, BUS_SEL
  );
endinterface

// File: rtl/sh7604_dbus_arb.sv
// sh7604_dbus_arb: SH7604 DBUS arbiter sharing the bus between CPU, DMAC and an external master.
// Ports: CLK, RST (async active-high), bus (slave modport: CE_R/CE_F enables, requests with
// lock/burst, EXT_BREQ, DBUS_WAIT in; registered GNT_CPU/GNT_DMA/EXT_BACK/BUS_SEL, CPU_WAIT, ACC_DONE out).
// Optional macro SH7604_ARB_FAIR_EN: DMA hold counter giving the CPU one slot every MAX_HOLD DMA accesses.
module sh7604_dbus_arb #(
  parameter int MAX_HOLD = 8
) (
  input logic CLK,
  input logic RST,
  sh7604_dbus_arb_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CPU, DMA, EXT, TURN} state_t;
  state_t state, nxt, pick;
  logic from_ext, done_q, acc, gnt_cpu, gnt_dma, gnt_ext;
  logic [1:0] sel;
  logic oreq, olock, compl, done_eff, rearb, arb, fair;
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be 1..255");
  end
  assign oreq = state == CPU ? bus.CPU_REQ : state == DMA ? bus.DMA_REQ : state == EXT ? bus.EXT_BREQ : 1'b0;
  assign olock = state == CPU ? (bus.CPU_LOCK | bus.CPU_BURST) :
                 state == DMA ? (bus.DMA_LOCK | bus.DMA_BURST) : 1'b0;
  assign compl = bus.CE_F & oreq & ~bus.DBUS_WAIT;
  // a completion sampled on the same CLK as CE_R is already visible to that update
  assign done_eff = done_q | compl;
  // a dropped request only releases the bus once the BSC is not stretching the access
  assign rearb = ~olock & (oreq ? done_eff : ~bus.DBUS_WAIT);
  assign arb = state == IDLE | ((state == CPU | state == DMA) & rearb);
`ifdef SH7604_ARB_FAIR_EN
  logic [7:0] cnt;
  logic [8:0] cnt_eff;
  logic dma_done;
  assign dma_done = compl & (state == DMA);
  assign cnt_eff = {1'b0, cnt} + {8'd0, dma_done};
  assign fair = (state == DMA) & bus.CPU_REQ & (cnt_eff >= 9'(MAX_HOLD));
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= 8'd0;
    else if (bus.CE_R & (nxt == CPU | state == IDLE)) cnt <= 8'd0;
    else if (dma_done & cnt != 8'hff) cnt <= cnt + 8'd1;
`else
  assign fair = 1'b0;
`endif
  always_comb begin
    pick = bus.EXT_BREQ ? TURN : fair ? CPU : bus.DMA_REQ ? DMA : bus.CPU_REQ ? CPU : IDLE;
    nxt = arb ? pick :
          state == EXT ? (bus.EXT_BREQ ? EXT : TURN) :
          state == TURN ? (from_ext ? IDLE : EXT) : state;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      from_ext <= 1'b0;
      done_q <= 1'b0;
      acc <= 1'b0;
      gnt_cpu <= 1'b0;
      gnt_dma <= 1'b0;
      gnt_ext <= 1'b0;
      sel <= 2'b00;
    end else begin
      acc <= compl;
      if (bus.CE_R) begin
        state <= nxt;
        from_ext <= state == EXT;
        done_q <= 1'b0;
        gnt_cpu <= nxt == CPU;
        gnt_dma <= nxt == DMA;
        gnt_ext <= nxt == EXT;
        sel <= nxt == CPU ? 2'b01 : nxt == DMA ? 2'b10 : nxt == EXT ? 2'b11 : 2'b00;
      end else if (compl) done_q <= 1'b1;
    end
  assign bus.GNT_CPU = gnt_cpu;
  assign bus.GNT_DMA = gnt_dma;
  assign bus.EXT_BACK = gnt_ext;
  assign bus.BUS_SEL = sel;
  assign bus.ACC_DONE = acc;
  assign bus.CPU_WAIT = bus.CPU_REQ & ~gnt_cpu;
endmodule

// File: tb/tb_sh7604_dbus_arb.sv
// tb_sh7604_dbus_arb: scoreboard bench for the DBUS arbiter.
module tb_sh7604_dbus_arb;
  localparam logic [7:0] CR = 8'h80, CL = 8'h40, CB = 8'h20, DR = 8'h10, EB = 8'h02, W = 8'h01;
  typedef struct packed {int id; logic acc; logic [1:0] sel; logic wt;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int sid = 0;
  exp_t sb[$];
  sh7604_dbus_arb_if bus();
  sh7604_dbus_arb #(.MAX_HOLD(8)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask
  task automatic drive(input logic [7:0] in);
    {bus.CPU_REQ, bus.CPU_LOCK, bus.CPU_BURST, bus.DMA_REQ, bus.DMA_LOCK, bus.DMA_BURST,
     bus.EXT_BREQ, bus.DBUS_WAIT} = in;
  endtask
  // one step = a CE_F clock (completion sample) then a CE_R clock (arbitration update)
  task automatic step(input logic [7:0] in, input logic ea, input logic [1:0] es);
    exp_t e;
    drive(in);
    sid++;
    e.id = sid;
    e.acc = ea;
    e.sel = es;
    e.wt = in[7] & (es != 2'b01);
    sb.push_back(e);
    bus.CE_F = 1'b1;
    bus.CE_R = 1'b0;
    @(negedge clk);
    bus.CE_F = 1'b0;
    bus.CE_R = 1'b1;
    @(negedge clk);
    bus.CE_R = 1'b0;
  endtask
  logic mon_r, mon_f, mon_acc;
  exp_t mon_e;
  initial begin
    mon_acc = 1'b0;
    forever begin
      @(posedge clk);
      mon_r = bus.CE_R;
      mon_f = bus.CE_F;
      #1;
      if (mon_f) mon_acc = bus.ACC_DONE;
      if (mon_r) begin
        if (sb.size() == 0) check("sb_underflow", 8'd1, 8'd0);
        else begin
          mon_e = sb.pop_front();
          check($sformatf("step%0d", mon_e.id),
                {1'b0, mon_acc, bus.ACC_DONE, bus.GNT_CPU, bus.GNT_DMA, bus.EXT_BACK, bus.BUS_SEL},
                {1'b0, mon_e.acc, 1'b0, mon_e.sel == 2'b01, mon_e.sel == 2'b10, mon_e.sel == 2'b11, mon_e.sel});
          check($sformatf("step%0d_cpu_wait", mon_e.id), {7'd0, bus.CPU_WAIT}, {7'd0, mon_e.wt});
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    bus.CE_R = 1'b0;
    bus.CE_F = 1'b0;
    drive(CR);
    #12;
    check("reset_outputs", {2'b0, bus.GNT_CPU, bus.GNT_DMA, bus.EXT_BACK, bus.BUS_SEL, bus.ACC_DONE}, 8'b0);
    check("reset_cpu_wait", {7'd0, bus.CPU_WAIT}, 8'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(CR, 1'b0, 2'b01);
    step(CR, 1'b1, 2'b01);
    step(CR, 1'b1, 2'b01);
    step(CR | CL | DR, 1'b1, 2'b01);
    step(CR | CL | DR, 1'b1, 2'b01);
    step(CR | DR, 1'b1, 2'b10);
    step(CR | DR, 1'b1, 2'b10);
    for (int i = 0; i < 4; i++) step(DR | EB | W, 1'b0, 2'b10);
    step(DR | EB, 1'b1, 2'b00);
    step(DR | EB, 1'b0, 2'b11);
    step(DR | EB | W, 1'b0, 2'b11);
    step(DR | W, 1'b0, 2'b00);
    step(DR | W, 1'b0, 2'b00);
    step(DR | W, 1'b0, 2'b10);
    step(W, 1'b0, 2'b10);
    step(8'h00, 1'b0, 2'b00);
    step(CR | DR, 1'b0, 2'b10);
    for (int i = 0; i < 18; i++)
`ifdef SH7604_ARB_FAIR_EN
      step(CR | DR, 1'b1, (i == 7 || i == 16) ? 2'b01 : 2'b10);
`else
      step(CR | DR, 1'b1, 2'b10);
`endif
    step(DR | EB, 1'b1, 2'b00);
    step(EB | W, 1'b0, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", {2'b0, bus.GNT_CPU, bus.GNT_DMA, bus.EXT_BACK, bus.BUS_SEL, bus.ACC_DONE}, 8'b0);
    drive(8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(CR, 1'b0, 2'b01);
    step(CR | CB | DR, 1'b1, 2'b01);
    step(CR | CB | DR, 1'b1, 2'b01);
    step(CR | DR, 1'b1, 2'b10);
    @(negedge clk);
    check("sb_drain", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
